// File: rtl/branch_predictor_btb_pkg.sv
// rtl/branch_predictor_btb_pkg.sv - shared constants and helpers for the branch target buffer
package branch_predictor_btb_pkg;

    localparam int INSTR_BYTES = 4;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Generalised weak encodings: MSB is the taken bit, the rest sit just below/above the midpoint
    function automatic int ctr_weak_nt(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int ctr_weak_t(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// rtl/branch_predictor_btb_sat_counter.sv - saturating up/down counter with parallel load
module sat_counter #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            if (inc_i && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!inc_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with per-entry direction counters and statistics
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              inv_all,
    output logic              mispredict,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int IDX_W = clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_INIT  = CTR_W'(ctr_weak_nt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_weak_t(CTR_W));

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [TAG_W-1:0]  up_tag;
    logic              upd_hit;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_val  [ENTRIES];
    logic [ENTRIES-1:0] ctr_en;
    logic [ENTRIES-1:0] ctr_load;

    logic [1:0] unused_pc_bits;
    assign unused_pc_bits = lookup_pc[1:0] ^ upd_pc[1:0];

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup sees only registered state, so a same-cycle update is not bypassed
    assign pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken   = pred_hit && ctr_val[lk_idx][CTR_W-1];
    assign pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(INSTR_BYTES);

    assign upd_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_en   = '0;
        ctr_load = '0;
        if (inv_all) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_en[up_idx] = 1'b1;
                if (upd_taken) begin
                    target_d[up_idx] = upd_target;
                end
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_load[up_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
        sat_counter #(
            .W       (CTR_W),
            .RST_VAL (CTR_INIT)
        ) u_ctr (
            .clk        (clk),
            .rst        (rst),
            .en_i       (ctr_en[e]),
            .inc_i      (upd_taken),
            .load_i     (ctr_load[e]),
            .load_val_i (CTR_ALLOC),
            .cnt_o      (ctr_val[e])
        );
    end

    // Statistics count every resolved branch, including ones dropped by inv_all
    sat_counter #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_br_count (
        .clk        (clk),
        .rst        (rst),
        .en_i       (upd_valid),
        .inc_i      (1'b1),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (br_count)
    );

    sat_counter #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_mispred_count (
        .clk        (clk),
        .rst        (rst),
        .en_i       (mispredict),
        .inc_i      (1'b1),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (mispred_count)
    );

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for the branch target buffer
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        inv_all = 1'b0;

    logic        pred_hit, pred_taken, mispredict;
    logic [31:0] pred_next_pc;
    logic [15:0] br_count, mispred_count;

    logic        pred_hit2, pred_taken2, mispredict2;
    logic [31:0] pred_next_pc2;
    logic [3:0]  br_count2, mispred_count2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        inv;
        logic [66:0] exp;
    } step_t;

    step_t       stim_q[$];
    logic [66:0] exp_q[$];
    logic [8:0]  sat_q[$];

    branch_predictor_btb #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .inv_all(inv_all),
        .mispredict(mispredict), .br_count(br_count), .mispred_count(mispred_count)
    );

    branch_predictor_btb #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit2), .pred_taken(pred_taken2), .pred_next_pc(pred_next_pc2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .inv_all(inv_all),
        .mispredict(mispredict2), .br_count(br_count2), .mispred_count(mispred_count2)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utgt, input logic upt,
                                 input logic [31:0] uptgt, input logic inv,
                                 input logic eh, input logic et, input logic [31:0] en,
                                 input logic em, input logic [15:0] ebr, input logic [15:0] emp);
        step_t s;
        s.lpc = lpc; s.uv = uv; s.upc = upc; s.ut = ut; s.utgt = utgt;
        s.upt = upt; s.uptgt = uptgt; s.inv = inv;
        s.exp = {eh, et, en, em, ebr, emp};
        return s;
    endfunction

    function automatic step_t look(input logic [31:0] lpc, input logic eh, input logic et,
                                   input logic [31:0] en, input logic [15:0] ebr,
                                   input logic [15:0] emp);
        return mk(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, eh, et, en, 1'b0, ebr, emp);
    endfunction

    function automatic logic [66:0] observed();
        return {pred_hit, pred_taken, pred_next_pc, mispredict, br_count, mispred_count};
    endfunction

    task automatic apply(input step_t s);
        lookup_pc       = s.lpc;
        upd_valid       = s.uv;
        upd_pc          = s.upc;
        upd_taken       = s.ut;
        upd_target      = s.utgt;
        upd_pred_taken  = s.upt;
        upd_pred_target = s.uptgt;
        inv_all         = s.inv;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        logic [66:0] e;
        int n = 0;
        stim_q.push_back(look(32'h40, 0, 0, 32'h44, 0, 0));
        while (stim_q.size() > 0) begin
            @(negedge clk); apply(stim_q.pop_front()); #1;
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL reset[%0d] got %h exp %h", n, observed(), e);
            end
            @(posedge clk); #1; upd_valid = 1'b0; inv_all = 1'b0; n++;
        end
        rst = 1'b0;
        stim_q.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 0, 0, 32'h44, 1, 0, 0));
        stim_q.push_back(look(32'h40, 1, 1, 32'h100, 1, 1));
        while (stim_q.size() > 0) begin
            @(negedge clk); apply(stim_q.pop_front()); #1;
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL reset[%0d] got %h exp %h", n, observed(), e);
            end
            @(posedge clk); #1; upd_valid = 1'b0; inv_all = 1'b0; n++;
        end
        @(negedge clk);
        lookup_pc = 32'h40;
        #2 rst = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'h44, 1'b0, 16'd0, 16'd0});
        #1;
        e = exp_q.pop_front(); checks++;
        if (observed() !== e) begin
            errors++; $display("FAIL async_reset got %h exp %h", observed(), e);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_alloc();
        logic [66:0] e;
        int n = 0;
        stim_q.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 0, 0, 32'h44, 1, 0, 0));
        stim_q.push_back(look(32'h40, 1, 1, 32'h100, 1, 1));
        while (stim_q.size() > 0) begin
            @(negedge clk); apply(stim_q.pop_front()); #1;
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL alloc[%0d] got %h exp %h", n, observed(), e);
            end
            @(posedge clk); #1; upd_valid = 1'b0; inv_all = 1'b0; n++;
        end
    endtask

    task automatic test_counter();
        logic [66:0] e;
        int n = 0;
        stim_q.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0, 1, 1, 32'h100, 1, 1, 1));
        stim_q.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0, 0, 32'h44, 0, 1, 0, 32'h44, 0, 2, 2));
        stim_q.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0, 0, 32'h44, 0, 1, 0, 32'h44, 0, 3, 2));
        stim_q.push_back(look(32'h40, 1, 0, 32'h44, 4, 2));
        stim_q.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 1, 0, 32'h44, 1, 4, 2));
        stim_q.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 1, 0, 32'h44, 1, 5, 3));
        stim_q.push_back(look(32'h40, 1, 1, 32'h100, 6, 4));
        while (stim_q.size() > 0) begin
            @(negedge clk); apply(stim_q.pop_front()); #1;
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL counter[%0d] got %h exp %h", n, observed(), e);
            end
            @(posedge clk); #1; upd_valid = 1'b0; inv_all = 1'b0; n++;
        end
    endtask

    task automatic test_alias();
        logic [66:0] e;
        int n = 0;
        stim_q.push_back(mk(32'h80, 1, 32'h80, 0, 32'h0, 0, 32'h84, 0, 0, 0, 32'h84, 0, 6, 4));
        stim_q.push_back(mk(32'h40, 1, 32'h80, 1, 32'h200, 0, 32'h84, 0, 1, 1, 32'h100, 1, 7, 4));
        stim_q.push_back(look(32'h80, 1, 1, 32'h200, 8, 5));
        stim_q.push_back(look(32'h40, 0, 0, 32'h44, 8, 5));
        while (stim_q.size() > 0) begin
            @(negedge clk); apply(stim_q.pop_front()); #1;
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL alias[%0d] got %h exp %h", n, observed(), e);
            end
            @(posedge clk); #1; upd_valid = 1'b0; inv_all = 1'b0; n++;
        end
    endtask

    task automatic test_same_cycle();
        logic [66:0] e;
        int n = 0;
        stim_q.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0, 0, 0, 32'h44, 1, 8, 5));
        stim_q.push_back(look(32'h40, 1, 1, 32'h100, 9, 6));
        stim_q.push_back(mk(32'h40, 1, 32'h40, 1, 32'h300, 1, 32'h100, 0, 1, 1, 32'h100, 1, 9, 6));
        stim_q.push_back(mk(32'h40, 1, 32'h44, 1, 32'h400, 1, 32'h400, 0, 1, 1, 32'h300, 0, 10, 7));
        stim_q.push_back(look(32'h44, 1, 1, 32'h400, 11, 7));
        stim_q.push_back(mk(32'h40, 1, 32'h80, 1, 32'h500, 0, 32'h84, 1, 1, 1, 32'h300, 1, 11, 7));
        stim_q.push_back(look(32'h40, 0, 0, 32'h44, 12, 8));
        stim_q.push_back(look(32'h80, 0, 0, 32'h84, 12, 8));
        stim_q.push_back(look(32'h44, 0, 0, 32'h48, 12, 8));
        while (stim_q.size() > 0) begin
            @(negedge clk); apply(stim_q.pop_front()); #1;
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin
                errors++; $display("FAIL same_cycle[%0d] got %h exp %h", n, observed(), e);
            end
            @(posedge clk); #1; upd_valid = 1'b0; inv_all = 1'b0; n++;
        end
    endtask

    task automatic test_saturation();
        logic [8:0]  e;
        logic [3:0]  v;
        logic [31:0] e32;
        @(negedge clk); rst = 1'b1;
        #1 rst = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            lookup_pc = 32'h40; upd_pc = 32'h40; upd_target = 32'h100;
            upd_pred_target = 32'h44; upd_pred_taken = 1'b0; upd_taken = 1'b1;
            inv_all = 1'b0;
            upd_valid = (k < 20);
            v = (k > 15) ? 4'd15 : 4'(k);
            sat_q.push_back({(k < 20) ? 1'b1 : 1'b0, v, v});
            #1;
            e = sat_q.pop_front(); checks++;
            if ({mispredict2, br_count2, mispred_count2} !== e) begin
                errors++;
                $display("FAIL saturation[%0d] got %h exp %h", k,
                         {mispredict2, br_count2, mispred_count2}, e);
            end
            @(posedge clk); #1; upd_valid = 1'b0;
        end
        e32 = {16'd20, 16'd20};
        checks++;
        if ({br_count, mispred_count} !== e32) begin
            errors++; $display("FAIL wide_counts got %h exp %h", {br_count, mispred_count}, e32);
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_same_cycle();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
